// File: rtl/fir_pkg.sv
// Shared constants and helpers for the three-tap filter and its output conditioner.
package fir_pkg;

    localparam int FIR_X_W    = 8;
    localparam int FIR_Y_W    = 16;
    localparam int COND_OUT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample FIFO; dout shows the head combinationally, zero-cycle read latency.
// A push while full is accepted only when a pop happens in the same cycle; pop while empty is ignored.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW    = clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot the concurrent push lands in, so full+pop still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fir_output_conditioner.sv
// Rounds, rescales and saturates the 17-bit filter result, then queues samples on a valid/ready stream.
// Two-edge latency to out_valid; when the FIFO is full with no pop, new samples are dropped and counted.
module fir_output_conditioner
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_Y_W,
    parameter int OUT_W = COND_OUT_W,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       y_in,
    input  logic                  carry_in,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [clog2(DEPTH):0] level
);

    localparam int                SUM_W = IN_W + 2;
    localparam logic [SUM_W-1:0]  RND   = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic [SUM_W-1:0] sum, rs;
    logic             sat;
    logic [OUT_W-1:0] samp;

    logic             stage_vld_q, stage_vld_d;
    logic [OUT_W-1:0] stage_dat_q, stage_dat_d;
    logic             sat_flag_q, sat_flag_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             fifo_empty, fifo_full, pop, drop;

    assign pop = ~fifo_empty & out_ready;

    always_comb begin
        // One spare headroom bit keeps the rounding add from wrapping at carry=1, y=all-ones.
        sum  = {1'b0, carry_in, y_in} + RND;
        rs   = sum >> SHIFT;
        sat  = |rs[SUM_W-1:OUT_W];
        samp = sat ? {OUT_W{1'b1}} : rs[OUT_W-1:0];

        stage_vld_d = in_valid;
        stage_dat_d = in_valid ? samp : stage_dat_q;
        sat_flag_d  = sat_flag_q | (in_valid & sat);

        drop       = stage_vld_q & fifo_full & ~pop;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
            stage_dat_q <= '0;
            sat_flag_q  <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            stage_vld_q <= stage_vld_d;
            stage_dat_q <= stage_dat_d;
            sat_flag_q  <= sat_flag_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    fir_sample_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stage_vld_q),
        .din   (stage_dat_q),
        .pop   (pop),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign out_valid = ~fifo_empty;
    assign sat_flag  = sat_flag_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Directed bench for fir_output_conditioner at SHIFT=4, OUT_W=8, DEPTH=4.
module tb_fir_output_conditioner;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] y_in;
    logic        carry_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    fir_output_conditioner #(
        .IN_W  (16),
        .OUT_W (8),
        .SHIFT (4),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .y_in      (y_in),
        .carry_in  (carry_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for a single edge.
    task automatic send(input logic [15:0] y, input logic c);
        in_valid = 1'b1;
        y_in     = y;
        carry_in = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        y_in = '0;
        carry_in = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (sat_flag !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_flags got sat=%b ovf=%b drop=%0d exp 0/0/0", sat_flag, overflow, drop_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(16'd256, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'd16) begin errors++; $display("FAIL basic_data got=%0d exp=16", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || level !== 3'd0)
            begin errors++; $display("FAIL basic_one_cycle got valid=%b level=%0d exp 0/0", out_valid, level); end
    endtask

    task automatic test_rounding();
        logic [15:0] ys  [3];
        logic [7:0]  exp [3];
        ys[0] = 16'd24; exp[0] = 8'd2;
        ys[1] = 16'd23; exp[1] = 8'd1;
        ys[2] = 16'd0;  exp[2] = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ys[i], 1'b0);
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i])
                begin errors++; $display("FAIL round_%0d got valid=%b data=%0d exp valid=1 data=%0d", ys[i], out_valid, out_data, exp[i]); end
            tick();
        end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat_flag got=%b exp=0", sat_flag); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        send(16'd4087, 1'b0);
        tick();
        checks++; if (out_data !== 8'd255 || out_valid !== 1'b1)
            begin errors++; $display("FAIL sat_edge_data got=%0d valid=%b exp=255 valid=1", out_data, out_valid); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_edge_flag got=%b exp=0", sat_flag); end
        tick();
        send(16'hFFFF, 1'b1);
        tick();
        checks++; if (out_data !== 8'd255 || out_valid !== 1'b1)
            begin errors++; $display("FAIL sat_max_data got=%0d valid=%b exp=255 valid=1", out_data, out_valid); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_max_flag got=%b exp=1", sat_flag); end
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            y_in     = 16'(16 * k);
            carry_in = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (level !== 3'd4)    begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        tick();
        checks++; if (out_data !== 8'd1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL ovf_hold got data=%0d valid=%b exp 1/1", out_data, out_valid); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(k))
                begin errors++; $display("FAIL ovf_drain_%0d got valid=%b data=%0d exp valid=1 data=%0d", k, out_valid, out_data, k); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || level !== 3'd0)
            begin errors++; $display("FAIL ovf_drained got valid=%b level=%0d exp 0/0", out_valid, level); end
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp [4];
        exp[0] = 8'd11; exp[1] = 8'd12; exp[2] = 8'd13; exp[3] = 8'd20;
        out_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            send(16'(16 * k), 1'b0);
        end
        tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_prefill got=%0d exp=4", level); end
        // Sample enters stage on this edge; the next edge pushes and pops together.
        send(16'd320, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 3'd4)    begin errors++; $display("FAIL fullpop_level got=%0d exp=4", level); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fullpop_drop_cnt got=%0d exp=2", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i])
                begin errors++; $display("FAIL fullpop_drain_%0d got valid=%b data=%0d exp valid=1 data=%0d", i, out_valid, out_data, exp[i]); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            send(16'(16 * k), 1'b0);
        end
        tick();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_prefill got=%0d exp=3", level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'd0)
            begin errors++; $display("FAIL mid_rst_fifo got valid=%b level=%0d data=%0d exp 0/0/0", out_valid, level, out_data); end
        checks++; if (sat_flag !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
            begin errors++; $display("FAIL mid_rst_flags got sat=%b ovf=%b drop=%0d exp 0/0/0", sat_flag, overflow, drop_cnt); end
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        send(16'd256, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd16)
            begin errors++; $display("FAIL mid_after got valid=%b data=%0d exp valid=1 data=16", out_valid, out_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
